r2sdf_bfly_16: RTL and testbench
================================

# r2sdf_bfly_16

Radix-2 single-path delay-feedback (SDF) butterfly stage for a 16-sample half-frame. It consumes the stage state code and the Q8 twiddle pair produced by the 16-entry twiddle ROM/sequencer and sits directly downstream of it in the 256-point FFT pipeline. It holds a 16-deep complex feedback delay line, performs the add/subtract butterfly, and applies the twiddle to the difference half-frame. Its output feeds the next stage's input.

## Interface
Parameters:
- DATA_W, 24: signed width of each real/imag sample and twiddle component.
- DEPTH, 16: feedback delay line length in complex samples. Power of two.
- TW_FRAC, 8: twiddle fraction bits. 256 represents 1.0.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: din is valid. Only qualifies advance in FILL.
- din_r, din_i  in  DATA_W: input sample, two's complement.
- state  in  2: stage phase from ROM. 0=FILL, 1=BFLY, 2=TWID, 3=HOLD.
- w_r, w_i  in  DATA_W: twiddle for the current cycle. Combinational from ROM and aligned with `state`.
- out_valid  out  1: registered.
- dout_r, dout_i  out  DATA_W: registered output sample.

## Operation
- Delay line: DEPTH-entry complex shift register. Head is the oldest entry; tail is the write slot.
- advance = (state==FILL && in_valid) || state==BFLY || state==TWID. HOLD never advances.
- On advance, the line shifts one place and writes the tail. No shift and no write otherwise.
- FILL: tail ← din. out_valid ← 0.
- BFLY: uses h = head and x = din (din is taken as valid; in_valid ignored).
  - dout ← h + x.
  - tail ← h − x.
  - out_valid ← 1.
- TWID: d = head.
  - dout ← d·w (complex), with re = d_r·w_r − d_i·w_i and im = d_r·w_i + d_i·w_r.
  - tail ← in_valid ? din : 0. This preloads the next frame's first half.
  - out_valid ← 1.
- HOLD: all state holds. out_valid ← 0. dout holds its last value.
- Arithmetic:
  - Butterfly add/sub is DATA_W bits and wraps modulo 2^DATA_W, with no growth.
  - Products are full 2·DATA_W bits. Each complex-product sum is formed at 2·DATA_W+1 bits, then arithmetic-shifted right by TW_FRAC, then truncated to DATA_W bits.
- Reset (async, any time, including mid-frame): the delay line, dout_r, dout_i and out_valid all go to 0. Sequencing restarts from the upstream ROM's reset.

## Timing
- Latency: 1 cycle from the advancing edge to dout/out_valid.
- Throughput: 1 complex sample per cycle in BFLY and TWID.
- One full frame is DEPTH FILL advances, then DEPTH BFLY cycles, then DEPTH TWID cycles. The first output appears on the cycle after the first BFLY cycle.
- A state change takes effect on the same edge. There is no pipeline bubble between BFLY→TWID or TWID→BFLY.
- Twiddle w_r/w_i is sampled on the same edge as the head entry it multiplies. No internal twiddle alignment register.
- Single register stage after the multiplier. The multiplier must close timing combinationally at the target clock.

## Configuration
- R2SDF_ROUND_EN defined:
  - 2^(TW_FRAC−1) (128) is added to each product sum before the shift. This is round-half-up.
- R2SDF_ROUND_EN undefined:
  - Plain arithmetic shift is used, which truncates toward −∞.
- Butterfly path is unaffected either way.

## Structure
- Shared package `fft_pkg`:
  - DATA_W and TW_FRAC defaults.
  - State encoding constants ST_FILL, ST_BFLY, ST_TWID, ST_HOLD.
  - Complex sample typedef {re, im}.
- Sub-module `cmul_q8`: combinational complex multiplier with scale and rounding. This is the only place R2SDF_ROUND_EN is tested.
- The top holds the delay line, butterfly mux and output registers.

## Test plan
- Basic frame: FILL din=n for n=0..15, then BFLY din=100 for 16 cycles, w=(256,0) throughout.
  - BFLY outputs: dout_r = n+100, dout_i = 0.
  - Following 16 TWID cycles: dout_r = n−100.
  - out_valid is high for exactly 32 cycles.
- Twiddle −j: head = (5, 7), w = (0, −256) in TWID → dout = (7, −5).
- Rounding: head = (3, 0), w = (251, 0).
  - Without R2SDF_ROUND_EN: dout_r = 2.
  - With R2SDF_ROUND_EN: dout_r = 3.
  - Head (−1, 0): dout_r = −1 in both builds.
- HOLD and gaps:
  - In FILL, drop in_valid for 3 cycles → no shift occurs, and the frame result is identical to the basic case.
  - state=3 for 4 cycles mid-BFLY → out_valid = 0, and dout is frozen.
- Wrap: head = 0x7FFFFF, din = 1 in BFLY → dout_r = 0x800000 and tail = 0x7FFFFE.
- Reset mid-TWID: assert rst_n low asynchronously → out_valid = 0 and dout = 0 immediately. After release, a new FILL gives outputs with no residue from the old frame.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: default widths, stage phase codes, complex sample type.
package fft_pkg;
    localparam int DATA_W_DEF  = 24;
    localparam int TW_FRAC_DEF = 8;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_BFLY = 2'd1;
    localparam logic [1:0] ST_TWID = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } cplx_t;
endpackage

// File: rtl/cmul_q8.sv
// Combinational complex multiply by a fixed-point twiddle, scaled by 2^-TW_FRAC.
// R2SDF_ROUND_EN selects round-half-up; otherwise the shift truncates toward -inf.
module cmul_q8 #(
    parameter int DATA_W  = 24,
    parameter int TW_FRAC = 8
) (
    input  logic signed [DATA_W-1:0] d_r,
    input  logic signed [DATA_W-1:0] d_i,
    input  logic signed [DATA_W-1:0] w_r,
    input  logic signed [DATA_W-1:0] w_i,
    output logic signed [DATA_W-1:0] p_r,
    output logic signed [DATA_W-1:0] p_i
);
    localparam int MW = 2 * DATA_W;
    localparam int PW = MW + 1;

    logic signed [MW-1:0] rr, ii, ri, ir;
    logic signed [PW-1:0] sum_r, sum_i;

    assign rr = MW'(d_r) * MW'(w_r);
    assign ii = MW'(d_i) * MW'(w_i);
    assign ri = MW'(d_r) * MW'(w_i);
    assign ir = MW'(d_i) * MW'(w_r);

`ifdef R2SDF_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(2 ** (TW_FRAC - 1));
    assign sum_r = PW'(rr) - PW'(ii) + RND;
    assign sum_i = PW'(ri) + PW'(ir) + RND;
`else
    assign sum_r = PW'(rr) - PW'(ii);
    assign sum_i = PW'(ri) + PW'(ir);
`endif

    assign p_r = DATA_W'(sum_r >>> TW_FRAC);
    assign p_i = DATA_W'(sum_i >>> TW_FRAC);
endmodule

// File: rtl/r2sdf_bfly_16.sv
// Radix-2 SDF butterfly stage: DEPTH-deep complex feedback line, add/sub butterfly,
// twiddle on the difference half-frame. Rounding mode set by R2SDF_ROUND_EN (see cmul_q8).
module r2sdf_bfly_16
    import fft_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 16,
    parameter int TW_FRAC = TW_FRAC_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] din_r,
    input  logic signed [DATA_W-1:0] din_i,
    input  logic [1:0]               state,
    input  logic signed [DATA_W-1:0] w_r,
    input  logic signed [DATA_W-1:0] w_i,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] dout_r,
    output logic signed [DATA_W-1:0] dout_i
);
    // Index 0 is the head (oldest), DEPTH-1 is the tail write slot.
    logic signed [DATA_W-1:0] dl_r [DEPTH];
    logic signed [DATA_W-1:0] dl_i [DEPTH];

    logic                     advance, nxt_v;
    logic signed [DATA_W-1:0] tail_r, tail_i, nxt_r, nxt_i, prod_r, prod_i;

    cmul_q8 #(.DATA_W(DATA_W), .TW_FRAC(TW_FRAC)) u_cmul (
        .d_r (dl_r[0]),
        .d_i (dl_i[0]),
        .w_r (w_r),
        .w_i (w_i),
        .p_r (prod_r),
        .p_i (prod_i)
    );

    always_comb begin
        advance = 1'b0;
        nxt_v   = 1'b0;
        tail_r  = din_r;
        tail_i  = din_i;
        nxt_r   = dout_r;
        nxt_i   = dout_i;
        case (state)
            ST_FILL: advance = in_valid;
            ST_BFLY: begin
                advance = 1'b1;
                nxt_v   = 1'b1;
                nxt_r   = dl_r[0] + din_r;
                nxt_i   = dl_i[0] + din_i;
                tail_r  = dl_r[0] - din_r;
                tail_i  = dl_i[0] - din_i;
            end
            ST_TWID: begin
                advance = 1'b1;
                nxt_v   = 1'b1;
                nxt_r   = prod_r;
                nxt_i   = prod_i;
                // Preload the next frame's first half, or zeros when nothing arrives.
                tail_r  = in_valid ? din_r : '0;
                tail_i  = in_valid ? din_i : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                dl_r[k] <= '0;
                dl_i[k] <= '0;
            end
            dout_r    <= '0;
            dout_i    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (advance) begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    dl_r[k] <= dl_r[k+1];
                    dl_i[k] <= dl_i[k+1];
                end
                dl_r[DEPTH-1] <= tail_r;
                dl_i[DEPTH-1] <= tail_i;
            end
            dout_r    <= nxt_r;
            dout_i    <= nxt_i;
            out_valid <= nxt_v;
        end
    end
endmodule

// File: tb/tb_r2sdf_bfly_16.sv
// Self-checking bench for r2sdf_bfly_16: table-driven frames, directed corners, and
// randomized frames against a queue-based reference model. Honors R2SDF_ROUND_EN.
module tb_r2sdf_bfly_16;
    localparam int DW = 24;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
    logic [1:0]           state = 2'd0;
    logic                 out_valid;
    logic signed [DW-1:0] dout_r, dout_i;

    int checks = 0;
    int failures = 0;

    r2sdf_bfly_16 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
        .state(state), .w_r(w_r), .w_i(w_i), .out_valid(out_valid),
        .dout_r(dout_r), .dout_i(dout_i)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int qr[$], qi[$];
    int m_r, m_i;
    bit m_v;

    function automatic int wrap24(input longint v);
        logic [DW-1:0] t;
        t = v[DW-1:0];
        return int'($signed(t));
    endfunction

    function automatic int scale(input longint s);
`ifdef R2SDF_ROUND_EN
        s = s + 128;
`endif
        return wrap24(s >>> 8);
    endfunction

    task automatic model_reset();
        qr.delete(); qi.delete();
        for (int k = 0; k < 16; k++) begin qr.push_back(0); qi.push_back(0); end
        m_r = 0; m_i = 0; m_v = 1'b0;
    endtask

    task automatic model_step(input int st, input bit iv, input int dr, input int di,
                              input int wr, input int wi);
        int hr, hi, tr, ti;
        bit adv;
        hr = qr[0]; hi = qi[0];
        tr = dr; ti = di;
        adv = (st == 0 && iv) || st == 1 || st == 2;
        m_v = (st == 1 || st == 2);
        if (st == 1) begin
            m_r = wrap24(longint'(hr) + dr); m_i = wrap24(longint'(hi) + di);
            tr  = wrap24(longint'(hr) - dr); ti  = wrap24(longint'(hi) - di);
        end else if (st == 2) begin
            m_r = scale(longint'(hr) * wr - longint'(hi) * wi);
            m_i = scale(longint'(hr) * wi + longint'(hi) * wr);
            tr  = iv ? dr : 0; ti = iv ? di : 0;
        end
        if (adv) begin
            void'(qr.pop_front()); void'(qi.pop_front());
            qr.push_back(tr); qi.push_back(ti);
        end
    endtask

    // ---------------- drive / check helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int st, input bit iv, input int dr, input int di,
                        input int wr, input int wi);
        @(negedge clk);
        state = 2'(st); in_valid = iv;
        din_r = DW'(dr); din_i = DW'(di); w_r = DW'(wr); w_i = DW'(wi);
        @(posedge clk);
        #1;
        model_step(st, iv, dr, di, wr, wi);
    endtask

    task automatic chk_model(input string name);
        chk({name, "_valid"}, int'(out_valid), int'(m_v));
        chk({name, "_r"}, int'(dout_r), m_r);
        chk({name, "_i"}, int'(dout_i), m_i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; state = 2'd3; in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int st; bit iv; int dr; int di; int wr; int wi;
        bit ev; bit cd; int er; int ei;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input int st, input bit iv, input int dr, input int wr,
                                input int wi, input bit ev, input bit cd, input int er);
        vec_t v;
        v.st = st; v.iv = iv; v.dr = dr; v.di = 0; v.wr = wr; v.wi = wi;
        v.ev = ev; v.cd = cd; v.er = er; v.ei = 0;
        return v;
    endfunction

    // Basic frame from the plan: FILL n, BFLY din=100 -> n+100, TWID w=1 -> n-100.
    task automatic build_frame(input bit gap, input bit hold);
        tbl.delete();
        for (int n = 0; n < 16; n++) begin
            tbl.push_back(mk(0, 1, n, 256, 0, 0, 0, 0));
            if (gap && n == 7)
                for (int g = 0; g < 3; g++) tbl.push_back(mk(0, 0, 999, 256, 0, 0, 0, 0));
        end
        for (int n = 0; n < 16; n++) begin
            tbl.push_back(mk(1, 0, 100, 256, 0, 1, 1, n + 100));
            if (hold && n == 7)
                for (int g = 0; g < 4; g++) tbl.push_back(mk(3, 1, 555, 99, 7, 0, 1, 107));
        end
        for (int n = 0; n < 16; n++) tbl.push_back(mk(2, 0, 0, 256, 0, 1, 1, n - 100));
    endtask

    task automatic run_table(input string name);
        int nv;
        nv = 0;
        foreach (tbl[k]) begin
            step(tbl[k].st, tbl[k].iv, tbl[k].dr, tbl[k].di, tbl[k].wr, tbl[k].wi);
            if (out_valid) nv++;
            chk($sformatf("%s_v%0d", name, k), int'(out_valid), int'(tbl[k].ev));
            if (tbl[k].cd) begin
                chk($sformatf("%s_r%0d", name, k), int'(dout_r), tbl[k].er);
                chk($sformatf("%s_i%0d", name, k), int'(dout_i), tbl[k].ei);
            end
        end
        chk({name, "_valid_count"}, nv, 32);
    endtask

    // Head (hr,hi) with zeros behind it; BFLY din=bdr on first cycle. Returns first
    // BFLY output and first TWID output (w applied only on that first TWID cycle).
    task automatic single_head(input int hr, input int hi, input int bdr, input int wr,
                               input int wi, output int br, output int tr, output int ti);
        step(0, 1, hr, hi, 256, 0);
        for (int n = 1; n < 16; n++) step(0, 1, 0, 0, 256, 0);
        step(1, 0, bdr, 0, 256, 0);
        br = int'(dout_r);
        for (int n = 1; n < 16; n++) step(1, 0, 0, 0, 256, 0);
        step(2, 0, 0, 0, wr, wi);
        tr = int'(dout_r); ti = int'(dout_i);
        for (int n = 1; n < 16; n++) step(2, 0, 0, 0, 256, 0);
    endtask

    function automatic int rnd24();
        logic [DW-1:0] t;
        t = DW'($urandom);
        return int'($signed(t));
    endfunction

    initial begin
        int br, tr, ti, cnt;
        model_reset();
        #13;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_r", int'(dout_r), 0);
        chk("reset_i", int'(dout_i), 0);
        rst_n = 1'b1;

        build_frame(0, 0); run_table("basic");
        build_frame(1, 0); run_table("gap");
        build_frame(0, 1); run_table("hold");

        single_head(5, 7, 0, 0, -256, br, tr, ti);
        chk("negj_r", tr, 7);
        chk("negj_i", ti, -5);
`ifdef R2SDF_ROUND_EN
        single_head(3, 0, 0, 251, 0, br, tr, ti); chk("round_pos", tr, 3);
`else
        single_head(3, 0, 0, 251, 0, br, tr, ti); chk("round_pos", tr, 2);
`endif
        single_head(-1, 0, 0, 251, 0, br, tr, ti); chk("round_neg", tr, -1);
        single_head(32'h7FFFFF, 0, 1, 256, 0, br, tr, ti);
        chk("wrap_sum", br, -8388608);
        chk("wrap_tail", tr, 8388606);

        // Async reset in the middle of TWID, then a clean frame.
        for (int n = 0; n < 16; n++) step(0, 1, rnd24(), rnd24(), 256, 0);
        for (int n = 0; n < 16; n++) step(1, 0, rnd24(), rnd24(), 256, 0);
        for (int n = 0; n < 5; n++) step(2, 1, rnd24(), rnd24(), rnd24() % 300, 77);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_r", int'(dout_r), 0);
        chk("arst_i", int'(dout_i), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        build_frame(0, 0); run_table("post_rst");

        // Randomized frames with gaps and holds against the model.
        do_reset();
        for (int f = 0; f < 4; f++) begin
            cnt = 0;
            while (cnt < 16) begin
                if ($urandom_range(0, 5) == 0) step(3, 1, rnd24(), rnd24(), rnd24(), rnd24());
                else begin
                    bit iv;
                    iv = 1'($urandom_range(0, 3) != 0);
                    if (iv) cnt++;
                    step(0, iv, rnd24(), rnd24(), rnd24(), rnd24());
                end
                chk_model($sformatf("rnd%0d_fill", f));
            end
            for (int n = 0; n < 16; n++) begin
                if ($urandom_range(0, 6) == 0) begin
                    step(3, 0, rnd24(), rnd24(), 0, 0);
                    chk_model($sformatf("rnd%0d_hold", f));
                end
                step(1, 1'($urandom_range(0, 1)), rnd24(), rnd24(), rnd24(), rnd24());
                chk_model($sformatf("rnd%0d_bfly", f));
            end
            for (int n = 0; n < 16; n++) begin
                step(2, 1'($urandom_range(0, 1)), rnd24(), rnd24(),
                     $urandom_range(0, 512) - 256, $urandom_range(0, 512) - 256);
                chk_model($sformatf("rnd%0d_twid", f));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
